ps2_rx_frame: RTL and testbench
===============================

PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

Interface
REQ-001 SHALL have parameter FILT_CYC, default 8: consecutive equal samples needed before filtered ps2_clk changes.
REQ-002 SHALL have parameter TOUT_CYC, default 100000: idle iCLK_50 cycles inside a frame before abort (2 ms at 50 MHz).
REQ-003 SHALL have port iCLK_50, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw keyboard clock, asynchronous.
REQ-006 SHALL have port ps2_dat, input, 1 bit: raw keyboard data, asynchronous; block never drives it (receive only).
REQ-007 SHALL have port raw_byte, output, 8 bits: last good frame payload, prefixes included.
REQ-008 SHALL have port raw_valid, output, 1 bit: one-cycle pulse per good frame.
REQ-009 SHALL have port code, output, 8 bits: last non-prefix scan code.
REQ-010 SHALL have port code_valid, output, 1 bit: one-cycle pulse per non-prefix good byte.
REQ-011 SHALL have port extended, output, 1 bit: E0 preceded code; valid with code_valid.
REQ-012 SHALL have port released, output, 1 bit: F0 preceded code; valid with code_valid.
REQ-013 SHALL have port parity_err, output, 1 bit: one-cycle pulse on bad parity.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse on bad stop bit or timeout.
REQ-015 SHALL have port busy, output, 1 bit: high whenever FSM is not IDLE.

Function
REQ-016 SHALL pass ps2_clk and ps2_dat through two-flop synchronizers before any use.
REQ-017 SHALL update filtered clock only after FILT_CYC consecutive identical synchronized samples; shorter glitches are ignored.
REQ-018 SHALL generate a one-cycle fall strobe on each 1->0 transition of the filtered clock; all data sampling uses synchronized ps2_dat on that cycle.
REQ-019 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-020 IDLE: fall with dat=0 -> DATA, bit counter=0; fall with dat=1 -> stay IDLE, no error.
REQ-021 DATA: each fall shifts dat in LSB first; after 8th bit -> PARITY.
REQ-022 PARITY: fall samples parity bit -> STOP.
REQ-023 STOP: fall samples stop bit -> IDLE; odd parity (XOR of 8 data + parity = 1) and stop=1 gives raw_valid; parity wrong gives parity_err only; stop=0 with parity good gives frame_err only; both wrong gives parity_err.
REQ-024 SHALL, in any non-IDLE state, count cycles since last fall; reaching TOUT_CYC pulses frame_err and returns to IDLE; count resets on every fall.
REQ-025 All pulses SHALL assert on the cycle after the fall strobe of the stop bit (timeout: cycle after count reaches TOUT_CYC); raw_byte/code hold until next good frame.
REQ-026 Prefix tracker: good byte 8'hE0 sets ext flag, 8'hF0 sets rel flag; neither produces code_valid.
REQ-027 Any other good byte SHALL pulse code_valid with code=byte, extended=ext, released=rel in the same cycle, then clear both flags.
REQ-028 parity_err or frame_err SHALL clear both prefix flags.
REQ-029 raw_valid and code_valid SHALL coincide for non-prefix bytes.

Reset
REQ-030 On reset low, FSM=IDLE, counters=0, prefix flags=0, synchronizers and filtered clock=1, all outputs 0; effective immediately, mid-frame included.
REQ-031 After reset release, first frame SHALL need a fresh start bit; partial frames in progress are discarded.

Structure
REQ-032 Package ps2_pkg SHALL hold the FSM state enum, constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0, and default FILT_CYC/TOUT_CYC values.
REQ-033 Sub-module ps2_filter SHALL contain synchronizer, glitch filter and fall-edge detector for ps2_clk; data path uses plain two-flop sync.

Verification
REQ-034 Frame 8'h1C, parity 0, stop 1 at 10 kHz -> one raw_valid and code_valid, code=8'h1C, extended=0, released=0.
REQ-035 Frames F0 then 1C -> raw_valid twice, code_valid once with code=8'h1C, released=1.
REQ-036 Frames E0, F0, 75 -> code_valid once, code=8'h75, extended=1, released=1; next 8'h1B gives both flags 0.
REQ-037 Frame 8'h23 with parity 1 -> parity_err pulse, no raw_valid; following good 8'h23 accepted.
REQ-038 Stop after 4 data bits for 2.1 ms -> frame_err pulse, busy falls; 3-cycle ps2_clk low glitches in IDLE -> no state change.
REQ-039 reset low during bit 5 -> outputs 0, IDLE; subsequent full frame 8'h2B decoded correctly.

Source files
------------

// File: rtl/ps2_rx_frame_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : ps2_pkg                                                       |
// | Purpose  : Shared types and constants for the PS/2 receive frame block:  |
// |            FSM state encoding, scan-code prefix bytes, parameter         |
// |            defaults and the frame parity helper.                         |
// | Contents : ps2_state_e, PS2_EXT, PS2_BRK, FILT_CYC_DEFAULT,              |
// |            TOUT_CYC_DEFAULT, ps2_parity_ok()                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ps2_pkg;

  // Receiver FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Scan-code prefix bytes: extended-key and break (key release).
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Defaults: 8-sample clock glitch filter, 2 ms frame timeout at 50 MHz.
  localparam int FILT_CYC_DEFAULT = 8;
  localparam int TOUT_CYC_DEFAULT = 100000;

  // PS/2 uses odd parity: the eight data bits plus the parity bit must
  // contain an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: ps2_rx_frame_if                                               |
// | Purpose  : Bundles the raw PS/2 lines and the decoded byte/scan-code     |
// |            outputs of the receive block.                                 |
// | Signals  : ps2_clk, ps2_dat     - raw keyboard lines (receive only)      |
// |            raw_byte, raw_valid  - every good frame, prefixes included    |
// |            code, code_valid     - non-prefix scan codes                  |
// |            extended, released   - E0 / F0 seen before code               |
// |            parity_err, frame_err- error pulses                           |
// |            busy                 - receiver is inside a frame             |
// | Modports : master - environment side (drives lines, observes results)    |
// |            slave  - receiver side (ps2_rx_frame)                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ps2_rx_frame_if;

  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] raw_byte;
  logic       raw_valid;
  logic [7:0] code;
  logic       code_valid;
  logic       extended;
  logic       released;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output ps2_clk, ps2_dat,
    input  raw_byte, raw_valid, code, code_valid, extended, released,
    input  parity_err, frame_err, busy
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output raw_byte, raw_valid, code, code_valid, extended, released,
    output parity_err, frame_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/ps2_rx_frame_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_filter                                                    |
// | Purpose  : Conditions the raw keyboard clock: two-flop synchronizer,     |
// |            FILT_CYC-sample glitch filter and 1->0 edge strobe.           |
// | Ports    : iCLK_50   in  - system clock                                  |
// |            reset     in  - asynchronous, active-low                      |
// |            i_ps2_clk in  - raw PS/2 clock                                |
// |            o_fall    out - one-cycle strobe on filtered clock fall       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILT_CYC = FILT_CYC_DEFAULT
) (
  input  wire logic iCLK_50,
  input  wire logic reset,
  input  wire logic i_ps2_clk,
  output logic      o_fall
);

  localparam int                  c_cnt_w    = $clog2(FILT_CYC + 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(FILT_CYC - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_filt;
  logic               r_fall;
  logic [c_cnt_w-1:0] r_cnt;

  // r_cnt counts consecutive synchronized samples that disagree with the
  // filtered level; any agreeing sample restarts it, so pulses shorter than
  // FILT_CYC cycles never reach the filtered output.
  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_filt  <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_ps2_clk;
      r_sync2 <= r_sync1;
      r_fall  <= 1'b0;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
        // Filter flips to the opposite level: a fall if it was high.
        r_fall <= r_filt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_rx_frame                                                  |
// | Purpose  : PS/2 keyboard receiver. Deframes 11-bit frames (start, 8 data |
// |            LSB first, odd parity, stop), reports every good byte, and    |
// |            folds E0/F0 prefixes into extended/released flags on the      |
// |            following scan code. Receive only; never drives the lines.    |
// | Ports    : iCLK_50 in - system clock, all state on rising edge           |
// |            reset   in - asynchronous, active-low                         |
// |            bus     slave modport of ps2_rx_frame_if (lines + results)    |
// | Params   : FILT_CYC - samples to accept a ps2_clk level change           |
// |            TOUT_CYC - idle cycles inside a frame before abort            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILT_CYC = FILT_CYC_DEFAULT,
  parameter int TOUT_CYC = TOUT_CYC_DEFAULT
) (
  input  wire logic     iCLK_50,
  input  wire logic     reset,
  ps2_rx_frame_if.slave bus
);

  localparam int                  c_tout_w   = $clog2(TOUT_CYC + 1);
  localparam logic [c_tout_w-1:0] c_tout_lim = c_tout_w'(TOUT_CYC);

  logic                w_fall;
  logic                r_dat_s1;
  logic                r_dat_s2;

  ps2_state_e          r_state;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_par;
  logic [c_tout_w-1:0] r_tout_cnt;
  logic                r_ext;
  logic                r_rel;

  logic [7:0]          r_raw_byte;
  logic                r_raw_valid;
  logic [7:0]          r_code;
  logic                r_code_valid;
  logic                r_extended;
  logic                r_released;
  logic                r_parity_err;
  logic                r_frame_err;

  ps2_filter #(
    .FILT_CYC (FILT_CYC)
  ) u_filter (
    .iCLK_50   (iCLK_50),
    .reset     (reset),
    .i_ps2_clk (bus.ps2_clk),
    .o_fall    (w_fall)
  );

  // Data line only needs metastability protection: it is sampled on the
  // fall strobe, which lags the real clock edge by the filter latency while
  // the keyboard holds data stable through the low phase.
  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_dat_s1 <= bus.ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_tout_cnt   <= '0;
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
      r_raw_byte   <= '0;
      r_raw_valid  <= 1'b0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_extended   <= 1'b0;
      r_released   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_raw_valid  <= 1'b0;
      r_code_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      // Inactivity counter: only runs inside a frame, restarts on each fall.
      if (r_state == ST_IDLE || w_fall) begin
        r_tout_cnt <= '0;
      end else begin
        r_tout_cnt <= r_tout_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          // A fall with data high is line noise or a stray edge, not a start.
          if (w_fall && !r_dat_s2) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end

        ST_DATA: begin
          if (w_fall) begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
        end

        ST_PARITY: begin
          if (w_fall) begin
            r_par   <= r_dat_s2;
            r_state <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
            // Parity is reported in preference to a bad stop bit.
            if (!ps2_parity_ok(r_shift, r_par)) begin
              r_parity_err <= 1'b1;
              r_ext        <= 1'b0;
              r_rel        <= 1'b0;
            end else if (!r_dat_s2) begin
              r_frame_err <= 1'b1;
              r_ext       <= 1'b0;
              r_rel       <= 1'b0;
            end else begin
              r_raw_byte  <= r_shift;
              r_raw_valid <= 1'b1;
              if (r_shift == PS2_EXT) begin
                r_ext <= 1'b1;
              end else if (r_shift == PS2_BRK) begin
                r_rel <= 1'b1;
              end else begin
                r_code       <= r_shift;
                r_code_valid <= 1'b1;
                r_extended   <= r_ext;
                r_released   <= r_rel;
                r_ext        <= 1'b0;
                r_rel        <= 1'b0;
              end
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Stalled frame: abandon it. Placed last so it overrides the case.
      if (r_state != ST_IDLE && r_tout_cnt == c_tout_lim) begin
        r_state     <= ST_IDLE;
        r_tout_cnt  <= '0;
        r_frame_err <= 1'b1;
        r_ext       <= 1'b0;
        r_rel       <= 1'b0;
      end
    end
  end

  assign bus.raw_byte   = r_raw_byte;
  assign bus.raw_valid  = r_raw_valid;
  assign bus.code       = r_code;
  assign bus.code_valid = r_code_valid;
  assign bus.extended   = r_extended;
  assign bus.released   = r_released;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ps2_rx_frame                                               |
// | Purpose  : Directed self-checking bench for ps2_rx_frame. PS/2 bit time  |
// |            and timeout are scaled down (80-cycle bit, 2000-cycle         |
// |            timeout) so the run stays short; the glitch filter keeps its  |
// |            default depth.                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ps2_rx_frame;

  localparam int TB_FILT = 8;
  localparam int TB_TOUT = 2000;
  localparam int HALF    = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(
    .FILT_CYC (TB_FILT),
    .TOUT_CYC (TB_TOUT)
  ) dut (
    .iCLK_50 (clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitors, sampled on the inactive edge.
  int         n_raw  = 0;
  int         n_code = 0;
  int         n_perr = 0;
  int         n_ferr = 0;
  logic [7:0] cap_code = 8'h00;
  logic       cap_ext  = 1'b0;
  logic       cap_rel  = 1'b0;

  always @(negedge clk) begin
    if (bus.raw_valid)  n_raw++;
    if (bus.parity_err) n_perr++;
    if (bus.frame_err)  n_ferr++;
    if (bus.code_valid) begin
      n_code++;
      cap_code = bus.code;
      cap_ext  = bus.extended;
      cap_rel  = bus.released;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends bits[0] .. bits[n-1]; data is set during the high phase and the
  // clock then falls, as a keyboard does. Ends with the clock high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_dat = bits[i];
      wait_cyc(HALF);
      bus.ps2_clk = 1'b0;
      wait_cyc(HALF);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bits({stop, par, d, 1'b0}, 11);
    bus.ps2_dat = 1'b1;
    wait_cyc(60);
  endtask

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;

    // Reset state
    wait_cyc(5);
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_raw_byte", 32'(bus.raw_byte),   32'h00);
    chk("rst_code",     32'(bus.code),       32'h00);
    chk("rst_flags",    32'({bus.extended, bus.released, bus.raw_valid, bus.code_valid}), 32'd0);
    chk("rst_errs",     32'({bus.parity_err, bus.frame_err}), 32'd0);
    rst_n = 1'b1;
    wait_cyc(20);

    // 3-cycle clock glitches with data low must not start a frame
    bus.ps2_dat = 1'b0;
    for (int g = 0; g < 4; g++) begin
      bus.ps2_clk = 1'b0;
      wait_cyc(3);
      bus.ps2_clk = 1'b1;
      wait_cyc(10);
    end
    wait_cyc(20);
    chk("glitch_busy", 32'(bus.busy), 32'd0);
    chk("glitch_cnt",  32'(n_raw + n_perr + n_ferr), 32'd0);
    bus.ps2_dat = 1'b1;
    wait_cyc(20);

    // Plain make code 1C
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("1c_nraw",  32'(n_raw),  32'd1);
    chk("1c_ncode", 32'(n_code), 32'd1);
    chk("1c_code",  32'(cap_code), 32'h1C);
    chk("1c_flags", 32'({cap_ext, cap_rel}), 32'd0);
    chk("1c_rawb",  32'(bus.raw_byte), 32'h1C);
    chk("1c_busy",  32'(bus.busy), 32'd0);

    // Break: F0 1C
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("brk_nraw",  32'(n_raw),  32'd3);
    chk("brk_ncode", 32'(n_code), 32'd2);
    chk("brk_code",  32'(cap_code), 32'h1C);
    chk("brk_flags", 32'({cap_ext, cap_rel}), 32'b01);

    // Extended break: E0 F0 75, then 1B with flags cleared
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("ext_nraw",  32'(n_raw),  32'd6);
    chk("ext_ncode", 32'(n_code), 32'd3);
    chk("ext_code",  32'(cap_code), 32'h75);
    chk("ext_flags", 32'({cap_ext, cap_rel}), 32'b11);
    send_frame(8'h1B, 1'b1, 1'b1);
    chk("1b_ncode", 32'(n_code), 32'd4);
    chk("1b_code",  32'(cap_code), 32'h1B);
    chk("1b_flags", 32'({cap_ext, cap_rel}), 32'b00);

    // E0 then 23 with bad parity: error clears the pending E0
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h23, 1'b1, 1'b1);
    chk("perr_nperr", 32'(n_perr), 32'd1);
    chk("perr_nraw",  32'(n_raw),  32'd8);
    chk("perr_rawb",  32'(bus.raw_byte), 32'hE0);
    send_frame(8'h23, 1'b0, 1'b1);
    chk("23_nraw",  32'(n_raw),  32'd9);
    chk("23_ncode", 32'(n_code), 32'd5);
    chk("23_code",  32'(cap_code), 32'h23);
    chk("23_flags", 32'({cap_ext, cap_rel}), 32'b00);

    // Bad stop with good parity -> frame_err only
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("stop_nferr", 32'(n_ferr), 32'd1);
    chk("stop_nperr", 32'(n_perr), 32'd1);
    chk("stop_nraw",  32'(n_raw),  32'd9);
    // Both wrong -> parity_err only
    send_frame(8'h23, 1'b1, 1'b0);
    chk("both_nperr", 32'(n_perr), 32'd2);
    chk("both_nferr", 32'(n_ferr), 32'd1);

    // F0 then a frame stalled after 4 data bits -> timeout, F0 discarded
    send_frame(8'hF0, 1'b1, 1'b1);
    send_bits({1'b1, 1'b1, 8'h1C, 1'b0}, 5);
    wait_cyc(1);
    chk("tout_busy_in", 32'(bus.busy), 32'd1);
    wait_cyc(1900);
    chk("tout_early_ferr", 32'(n_ferr), 32'd1);
    chk("tout_early_busy", 32'(bus.busy), 32'd1);
    wait_cyc(200);
    chk("tout_ferr", 32'(n_ferr), 32'd2);
    chk("tout_busy", 32'(bus.busy), 32'd0);
    bus.ps2_dat = 1'b1;
    wait_cyc(20);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("tout_nraw",  32'(n_raw),  32'd11);
    chk("tout_ncode", 32'(n_code), 32'd6);
    chk("tout_flags", 32'({cap_ext, cap_rel}), 32'b00);

    // Reset during data bit 5, then a full 2B frame
    send_bits({1'b1, 1'b1, 8'h2B, 1'b0}, 6);
    wait_cyc(10);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_rawb", 32'(bus.raw_byte), 32'h00);
    chk("mrst_code", 32'(bus.code), 32'h00);
    chk("mrst_flags", 32'({bus.extended, bus.released}), 32'd0);
    rst_n = 1'b1;
    bus.ps2_dat = 1'b1;
    wait_cyc(20);
    send_frame(8'h2B, 1'b1, 1'b1);
    chk("2b_nraw",  32'(n_raw),  32'd12);
    chk("2b_ncode", 32'(n_code), 32'd7);
    chk("2b_code",  32'(cap_code), 32'h2B);
    chk("2b_rawb",  32'(bus.raw_byte), 32'h2B);
    chk("2b_flags", 32'({cap_ext, cap_rel}), 32'b00);
    chk("2b_errs",  32'(n_perr + n_ferr), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
